// File: rtl/subleq_boot_mem.sv
// subleq_boot_mem: boot loader, word memory and post-halt dump controller beneath a Subleq core
// Ports: clk, reset (async active-low); ld_valid/ld_data/ld_last/ld_ready host byte loader;
//        core_reset/core_addr/core_we/core_wdata/core_rdata/core_halt core side;
//        dump_valid/dump_data/dump_last/dump_ready host byte dump; loaded_words, done status.
// Option: define SUBLEQ_MEM_DUMP_EN for the DUMP state and dump port; otherwise halt goes straight to DONE.
module subleq_boot_mem #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int DUMP_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              core_reset,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_we,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              core_halt,
    output logic              dump_valid,
    output logic [7:0]        dump_data,
    output logic              dump_last,
    input  logic              dump_ready,
    output logic [ADDR_W:0]   loaded_words,
    output logic              done
);
    localparam int BPW = DATA_W / 8;
    localparam int BW  = BPW > 1 ? $clog2(BPW) : 1;
    typedef enum logic [1:0] {LOAD, RUN, DUMP, DONE} state_t;
    state_t            state_q, state_d, halt_state;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [BW-1:0]     bidx_q, bidx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [ADDR_W:0]   loaded_q, loaded_d;
    logic [DATA_W-1:0] mem [0:2**ADDR_W-1];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, ld_word;
    logic              word_end, dump_done;
    // Unfilled low bytes of word_q are kept zero so a short final word is padded for free.
    assign ld_word      = word_q | (DATA_W'(ld_data) << (8 * (BPW - 1 - int'(bidx_q))));
    assign word_end     = ld_last || bidx_q == BW'(BPW - 1);
    assign ld_ready     = state_q == LOAD;
    assign core_reset   = state_q != RUN;
    assign done         = state_q == DONE;
    assign core_rdata   = mem[core_addr];
    assign loaded_words = loaded_q;
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        bidx_d    = bidx_q;
        word_d    = word_q;
        loaded_d  = loaded_q;
        mem_we    = 1'b0;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        if (state_q == LOAD && ld_valid) begin
            bidx_d = word_end ? '0 : bidx_q + 1'b1;
            word_d = word_end ? '0 : ld_word;
            if (word_end) begin
                mem_we    = 1'b1;
                mem_addr  = wptr_q;
                mem_wdata = ld_word;
                wptr_d    = wptr_q + 1'b1;
                loaded_d  = loaded_q + 1'b1;
                // Filling the top address ends loading so no byte is accepted past the array.
                state_d   = (ld_last || wptr_q == '1) ? RUN : LOAD;
            end
        end
        if (state_q == RUN) begin
            mem_we  = core_we;
            state_d = core_halt ? halt_state : RUN;
        end
        if (dump_done) state_d = DONE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= LOAD;
            wptr_q   <= '0;
            bidx_q   <= '0;
            word_q   <= '0;
            loaded_q <= '0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            bidx_q   <= bidx_d;
            word_q   <= word_d;
            loaded_q <= loaded_d;
        end
    end
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
`ifdef SUBLEQ_MEM_DUMP_EN
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [BW-1:0]     rbyte_q, rbyte_d;
    logic [DATA_W-1:0] dump_sh;
    logic              byte_end;
    // Memory is frozen outside RUN, so the byte read straight from the array stays stable while stalled.
    assign dump_valid = state_q == DUMP;
    assign dump_sh    = mem[rptr_q] >> (8 * (BPW - 1 - int'(rbyte_q)));
    assign dump_data  = dump_valid ? dump_sh[7:0] : 8'h00;
    assign byte_end   = rbyte_q == BW'(BPW - 1);
    assign dump_last  = dump_valid && byte_end && rptr_q == ADDR_W'(DUMP_WORDS - 1);
    assign dump_done  = dump_last && dump_ready;
    assign halt_state = DUMP;
    always_comb begin
        rptr_d  = rptr_q;
        rbyte_d = rbyte_q;
        if (dump_valid && dump_ready) begin
            rbyte_d = byte_end ? '0 : rbyte_q + 1'b1;
            rptr_d  = byte_end ? rptr_q + 1'b1 : rptr_q;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr_q  <= '0;
            rbyte_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            rbyte_q <= rbyte_d;
        end
    end
`else
    logic unused_dump;
    assign unused_dump = dump_ready ^ (DUMP_WORDS != 0);
    assign dump_valid  = 1'b0;
    assign dump_data   = 8'h00;
    assign dump_last   = 1'b0;
    assign dump_done   = 1'b0;
    assign halt_state  = DONE;
`endif
endmodule

// File: tb/tb_subleq_boot_mem.sv
// tb_subleq_boot_mem: scoreboard bench for subleq_boot_mem with directed load/run/dump vectors
module tb_subleq_boot_mem;
    localparam int AW = 4;
    localparam int DW = 32;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_data = 8'h00;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          core_reset;
    logic [AW-1:0] core_addr = '0;
    logic          core_we = 1'b0;
    logic [DW-1:0] core_wdata = '0;
    logic [DW-1:0] core_rdata;
    logic          core_halt = 1'b0;
    logic          dump_valid;
    logic [7:0]    dump_data;
    logic          dump_last;
    logic          dump_ready = 1'b0;
    logic [AW:0]   loaded_words;
    logic          done;
    int            n_chk = 0;
    int            n_fail = 0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_q [$];
    logic [8:0]    dq [$];

    subleq_boot_mem #(.ADDR_W(AW), .DATA_W(DW), .DUMP_WORDS(2)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .core_reset(core_reset), .core_addr(core_addr), .core_we(core_we),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_halt(core_halt),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_last(dump_last),
        .dump_ready(dump_ready), .loaded_words(loaded_words), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: reads and dump bytes are compared against the queues the stimulus filled.
    always @(negedge clk) begin
        if (rd_en) begin
            if (rd_q.size() == 0) check("rd_queue_size", rd_q.size(), 1);
            else check("core_rdata", core_rdata, rd_q.pop_front());
        end
        if (dump_valid) begin
            if (dq.size() == 0) check("dump_queue_size", dq.size(), 1);
            else if (dump_ready) check("dump_byte", {dump_last, dump_data}, dq.pop_front());
            else check("dump_hold", {dump_last, dump_data}, dq[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        core_addr = a;
        rd_en     = 1'b1;
        rd_q.push_back(exp);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b0;
        #1;
        check("rst_ld_ready", ld_ready, 1);
        check("rst_core_reset", core_reset, 1);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_dump_data", dump_data, 0);
        check("rst_dump_last", dump_last, 0);
        check("rst_done", done, 0);
        check("rst_loaded_words", loaded_words, 0);
        dq.delete();
        reset = 1'b1;
        tick();
    endtask

    task automatic halt(input logic [7:0] img [$]);
        core_halt = 1'b1;
        tick();
        core_halt = 1'b0;
        core_we   = 1'b0;
`ifdef SUBLEQ_MEM_DUMP_EN
        foreach (img[i]) dq.push_back({i == img.size() - 1, img[i]});
`else
        check("halt_img_len", img.size(), 8);
`endif
    endtask

    task automatic drain();
        int cyc = 0;
`ifdef SUBLEQ_MEM_DUMP_EN
        while (!done && cyc < 64) begin
            dump_ready = (cyc % 2 == 0);
            tick();
            cyc++;
        end
        dump_ready = 1'b0;
        check("dump_cycles", cyc, 15);
        check("dump_queue_left", dq.size(), 0);
`endif
        check("done", done, 1);
        check("done_dump_valid", dump_valid, 0);
        check("done_core_reset", core_reset, 1);
        check("done_ld_ready", ld_ready, 0);
    endtask

    initial begin
        logic [7:0] img [$];
        #2 reset = 1'b0;
        repeat (2) tick();
        pulse_reset();
        core_we    = 1'b1;
        core_addr  = 4'd5;
        core_wdata = 32'h0000_1234;
        for (int k = 0; k < 64; k++) send(8'(k), 1'b0);
        core_we = 1'b0;
        check("wrap_loaded_words", loaded_words, 16);
        check("wrap_ld_ready", ld_ready, 0);
        check("wrap_core_reset", core_reset, 0);
        ld_valid = 1'b1;
        ld_data  = 8'hFF;
        ld_last  = 1'b1;
        #1 check("byte65_ld_ready", ld_ready, 0);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("byte65_loaded_words", loaded_words, 16);
        for (int a = 0; a < 16; a++) rd(4'(a), {8'(4 * a), 8'(4 * a + 1), 8'(4 * a + 2), 8'(4 * a + 3)});
        core_addr  = 4'd5;
        core_we    = 1'b1;
        core_wdata = 32'h0000_1234;
        tick();
        core_we = 1'b0;
        rd(4'd5, 32'h0000_1234);
        img = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        halt(img);
        drain();
        pulse_reset();
        img = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        foreach (img[i]) send(img[i], i == 7);
        check("t1_loaded_words", loaded_words, 2);
        check("t1_ld_ready", ld_ready, 0);
        check("t1_core_reset", core_reset, 0);
        rd(4'd0, 32'h0000_0001);
        rd(4'd1, 32'hDEAD_BEEF);
        rd(4'd2, 32'h0809_0A0B);
        rd(4'd5, 32'h0000_1234);
        core_addr  = 4'd7;
        core_we    = 1'b1;
        core_wdata = 32'hCAFE_F00D;
        halt(img);
        rd(4'd7, 32'hCAFE_F00D);
`ifdef SUBLEQ_MEM_DUMP_EN
        for (int i = 0; i < 5; i++) begin
            dump_ready = (i % 2 == 0);
            tick();
        end
        dump_ready = 1'b0;
        check("mid_dump_queue", dq.size(), 5);
`else
        check("halt_done", done, 1);
`endif
        pulse_reset();
        for (int i = 0; i < 4; i++) send(img[i], i == 3);
        check("t5_loaded_words", loaded_words, 1);
        check("t5_core_reset", core_reset, 0);
        rd(4'd1, 32'hDEAD_BEEF);
        halt(img);
        drain();
        pulse_reset();
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        foreach (img[i]) send(img[i], i == 4);
        check("t2_loaded_words", loaded_words, 2);
        check("t2_ld_ready", ld_ready, 0);
        check("t2_core_reset", core_reset, 0);
        rd(4'd0, 32'h1122_3344);
        rd(4'd1, 32'h5500_0000);
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00};
        halt(img);
        drain();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1);
    end
endmodule
